unsigned_mul_8x8_ha_array_accum: RTL and testbench
==================================================

# unsigned_mul_8x8_ha_array_accum

Sequential final-summation stage that consumes the four half-adder-array rows of the 8x8 unsigned approximate multiplier and produces the 16-bit product. Each row is a (top, bottom) vector pair at its own weight. The block captures all eight vectors in a single valid/ready handshake. It then accumulates one row per cycle into a 16-bit register and presents the product with a valid/ready output handshake. It sits directly downstream of the combinational partial-product/HA-array stage and trades a few cycles of latency for a single small adder.

## Interface

Parameters:
- `NUM_ROWS`, default 4: number of HA-array rows. Fixed at 4 for the 8x8 multiplier.
- `OUT_W`, default 16: width of the product and accumulator.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: row set on the input ports is valid.
- `in_ready`, output, 1: block can accept a row set.
- `ha_array_0_t` … `ha_array_3_t`, input, 9 each: row k top vector. Bit i has weight 2^(2k+i).
- `ha_array_0_b` … `ha_array_3_b`, input, 7 each: row k bottom/carry vector. Bit j has weight 2^(2k+j+2).
- `out_valid`, output, 1: `product` and `out_ovf` are valid.
- `out_ready`, input, 1: consumer accepts the output.
- `product`, output, 16: sum of the weighted rows, modulo 2^16.
- `out_ovf`, output, 1: the true sum was ≥ 2^16 (a carry was lost).

## Operation

Row value and result:
- Row value: R_k = t_k + (b_k << 2). This fits in 10 bits, max 1019.
- Result: sum over k of R_k << 2k.

States:
- `IDLE`:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: register all 8 vectors, clear the accumulator and `ovf`, set row counter `cnt`=0, go to `ACCUM`.
- `ACCUM`:
  - `in_ready`=0.
  - Each cycle: acc <= acc + (R_cnt << 2·cnt), computed in 17 bits. Bit 16 ORs into the sticky `ovf`. The low 16 bits are kept.
  - `cnt` increments each cycle. When `cnt`==NUM_ROWS-1, go to `DONE`.
- `DONE`:
  - `out_valid`=1; `product`=acc; `out_ovf`=ovf.
  - Outputs are held stable while `out_ready`=0.
  - On `out_ready`=1, go to `IDLE`.

Input capture rules:
- Input vectors are sampled only on the accepting edge. Changes to the inputs after acceptance have no effect.
- `in_valid` outside `IDLE` is ignored. The upstream holds its data until `in_ready` is seen.

Width rules:
- All arithmetic is unsigned.
- Addition is modulo 2^16 with overflow tracked.
- Row sets from an exact 8x8 multiply never set `out_ovf`.

Reset behaviour:
- Reset values: state=`IDLE`, `in_ready`=1, `out_valid`=0, `product`=0, `out_ovf`=0, `cnt`=0, accumulator=0.
- `rst` in any state, including mid-`ACCUM` and `DONE` with backpressure, aborts the current operation. No output is produced for that operation.

## Timing

- Acceptance edge E0.
- Edges E1–E4 add rows 0–3. E4 also enters `DONE`.
- `out_valid` is high in the cycle after E4, i.e. a latency of 4 cycles from acceptance.
- With `out_ready` held at 1:
  - The output handshake completes at E5.
  - `in_ready` is high after E5, and the next acceptance is at E6 at the earliest.
  - Throughput is therefore one product per 6 cycles.
- Simultaneous `in_valid` and output handshake in `DONE`: the input is not accepted in that cycle.
- `rst` has priority over every handshake in the same cycle.

## Test plan

- Row 0 only, t=9'h001, all others zero, `out_ready`=1 → `out_valid` exactly 4 cycles after acceptance; `product`=1, `out_ovf`=0. `out_valid` drops after 1 cycle.
- Row 3 only, b=7'h01, others zero → `product`=256. Row 2 only, t=9'h100 → `product`=4096.
- Row set for exact 255×255 (all rows t=9'h1FF, b=7'h7F except as the exact front-end produces), then synthetic all-ones on all rows → `product`=21079 (86615 mod 65536), `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles in `DONE` → `product`/`out_valid` stable, `in_ready`=0; a new `in_valid` during this is ignored. Release → handshake; `in_ready`=1 next cycle.
- Assert `rst` for 1 cycle while `cnt`=2 → next cycle `IDLE`, `in_ready`=1, `out_valid`=0, `product`=0. A following row set (row 1 t=9'h003 → 12) completes correctly with no residue.
- Input vectors changed on the cycle after acceptance → result reflects the originally sampled values.

Source files
------------

// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Final summation of the 8x8 approximate multiplier HA-array rows.
// Captures four (top, bottom) row pairs, then adds one weighted row per cycle.
module unsigned_mul_8x8_ha_array_accum #(
    parameter int NUM_ROWS = 4,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [8:0]       r_t [NUM_ROWS];
    logic [6:0]       r_b [NUM_ROWS];

    logic [8:0]       w_t_in [NUM_ROWS];
    logic [6:0]       w_b_in [NUM_ROWS];
    logic             w_accept;
    logic [9:0]       w_row;
    logic [CNT_W:0]   w_shamt;
    logic [OUT_W-1:0] w_addend;
    logic [OUT_W:0]   w_sum;

    assign w_t_in[0] = ha_array_0_t;
    assign w_t_in[1] = ha_array_1_t;
    assign w_t_in[2] = ha_array_2_t;
    assign w_t_in[3] = ha_array_3_t;
    assign w_b_in[0] = ha_array_0_b;
    assign w_b_in[1] = ha_array_1_b;
    assign w_b_in[2] = ha_array_2_b;
    assign w_b_in[3] = ha_array_3_b;

    assign w_accept = r_in_ready && in_valid;

    // Row k sits at weight 2^(2k); the bottom vector is a further 2 bits up.
    assign w_row    = {1'b0, r_t[r_cnt]} + {1'b0, r_b[r_cnt], 2'b00};
    assign w_shamt  = {r_cnt, 1'b0};
    assign w_addend = {{(OUT_W-10){1'b0}}, w_row} << w_shamt;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NUM_ROWS; k++) begin
                r_t[k] <= w_t_in[k];
                r_b[k] <= w_b_in[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc      <= '0;
                        r_ovf      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_sum[OUT_W-1:0];
                    r_ovf <= r_ovf | w_sum[OUT_W];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NUM_ROWS-1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_acc;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// Scoreboard bench for the HA-array accumulator: directed row sets,
// exact multiplies through a bench-side HA front-end, backpressure and reset.
module tb_unsigned_mul_8x8_ha_array_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  t [4];
    logic [6:0]  b [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        out_ovf;

    unsigned_mul_8x8_ha_array_accum dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (t[0]),
        .ha_array_1_t (t[1]),
        .ha_array_2_t (t[2]),
        .ha_array_3_t (t[3]),
        .ha_array_0_b (b[0]),
        .ha_array_1_b (b[1]),
        .ha_array_2_b (b[2]),
        .ha_array_3_b (b[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .out_ovf      (out_ovf)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cyc;
    logic [16:0] exp_q [$];
    logic [8:0]  st [4];
    logic [6:0]  sbv [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [16:0] row_model();
        int s = 0;
        for (int k = 0; k < 4; k++)
            s += (int'(st[k]) + (int'(sbv[k]) << 2)) << (2 * k);
        return {(s >= 65536), s[15:0]};
    endfunction

    // Exact half-adder array: row k pairs multiplier bits 2k and 2k+1.
    task automatic ha_rows(input logic [7:0] a, input logic [7:0] y);
        logic [7:0] p0, p1;
        for (int k = 0; k < 4; k++) begin
            p0 = a & {8{y[2*k]}};
            p1 = a & {8{y[2*k+1]}};
            st[k][0] = p0[0];
            for (int i = 1; i < 8; i++) st[k][i] = p0[i] ^ p1[i-1];
            st[k][8] = p1[7];
            for (int j = 0; j < 7; j++) sbv[k][j] = p0[j+1] & p1[j];
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            st[k]  = '0;
            sbv[k] = '0;
        end
    endtask

    task automatic send(input logic [16:0] e);
        int n = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            t[k] = st[k];
            b[k] = sbv[k];
        end
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("acc_tmo", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                chk("out_tmo", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !out_valid) break;
            n++;
            if (n > 50) begin
                chk("idle_tmo", 0, 1);
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexp_out", 1, 0);
            else chk("prod", {15'd0, out_ovf, product}, {15'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int          lat;
        int          a0;
        logic [7:0]  ra, rb;
        logic [15:0] p;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t[k] = '0;
            b[k] = '0;
        end
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ird", in_ready, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_prod", product, 0);
        chk("rst_ovf", out_ovf, 0);

        // row 0 only, latency
        clr();
        st[0] = 9'h001;
        send(17'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            if (!out_valid) lat++;
        end
        chk("lat", lat, 4);
        @(negedge clk);
        chk("ov_drop", out_valid, 0);
        chk("ird_back", in_ready, 1);

        clr();
        sbv[3] = 7'h01;
        send(17'd256);
        wait_idle();
        clr();
        st[2] = 9'h100;
        send(17'd4096);
        wait_idle();

        // exact 255x255, then synthetic all-ones
        ha_rows(8'hFF, 8'hFF);
        send({1'b0, 16'd65025});
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            st[k]  = 9'h1FF;
            sbv[k] = 7'h7F;
        end
        send({1'b1, 16'd21079});
        wait_idle();

        // back-to-back throughput
        ha_rows(8'd13, 8'd201);
        send({1'b0, 16'd2613});
        a0 = acc_cyc;
        ha_rows(8'd77, 8'd3);
        send({1'b0, 16'd231});
        chk("thru", acc_cyc - a0, 6);
        wait_idle();

        // backpressure, with an ignored in_valid
        out_ready = 1'b0;
        clr();
        st[0]  = 9'd5;
        sbv[0] = 7'd2;
        send(17'd13);
        wait_out();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            t[0] = 9'h1FF;
            t[3] = 9'h1FF;
            @(negedge clk);
            chk("bp_ov", out_valid, 1);
            chk("bp_prod", product, 13);
            chk("bp_ird", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("hs_ird", in_ready, 1);
        chk("hs_ov", out_valid, 0);

        // reset at cnt==2
        clr();
        st[0] = 9'd7;
        send(row_model());
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rr_ird", in_ready, 1);
        chk("rr_ov", out_valid, 0);
        chk("rr_prod", product, 0);
        clr();
        st[1] = 9'h003;
        send(17'd12);
        wait_idle();

        // reset in DONE under backpressure
        out_ready = 1'b0;
        clr();
        st[3] = 9'h0FF;
        send(row_model());
        wait_out();
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rd_ov", out_valid, 0);
        chk("rd_ird", in_ready, 1);

        // inputs changed after acceptance
        clr();
        st[2]  = 9'h0AB;
        sbv[2] = 7'h11;
        send(row_model());
        t[2] = 9'h000;
        b[2] = 7'h7F;
        t[0] = 9'h1FF;
        wait_idle();

        // random exact multiplies through the HA front-end
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            p  = ra * rb;
            ha_rows(ra, rb);
            send({1'b0, p});
        end
        wait_idle();
        repeat (2) @(negedge clk);

        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
